// File: rtl/vec_normalize_scheduler.sv
// Round-robin front end for one shared, fixed-latency vector-normalize pipeline.
// Grants at most one requester per cycle and registers its operands into the pipeline.
// A {valid, id} tag delay line tracks each issue so the result is routed back to its requester.
module vec_normalize_scheduler #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 9,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [27*N_REQ-1:0]           i_req_x,
  input  logic [27*N_REQ-1:0]           i_req_y,
  input  logic [27*N_REQ-1:0]           i_req_z,
  output logic [N_REQ-1:0]              o_req_ready,
  input  logic                          i_stall,
  output logic                          o_pipe_valid,
  output logic [26:0]                   o_pipe_x,
  output logic [26:0]                   o_pipe_y,
  output logic [26:0]                   o_pipe_z,
  input  logic [26:0]                   i_pipe_x,
  input  logic [26:0]                   i_pipe_y,
  input  logic [26:0]                   i_pipe_z,
  output logic [N_REQ-1:0]              o_rsp_valid,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic [26:0]                   o_rsp_x,
  output logic [26:0]                   o_rsp_y,
  output logic [26:0]                   o_rsp_z,
  output logic [$clog2(LATENCY+3)-1:0]  o_inflight,
  output logic                          o_busy
);

  localparam int CNT_W = $clog2(LATENCY + 3);

  logic [26:0]     req_x [N_REQ];
  logic [26:0]     req_y [N_REQ];
  logic [26:0]     req_z [N_REQ];

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;
  logic [26:0]     sel_x;
  logic [26:0]     sel_y;
  logic [26:0]     sel_z;

  logic            tag_v  [LATENCY+1];
  logic [ID_W-1:0] tag_id [LATENCY+1];

  logic [CNT_W-1:0] inflight;
  logic             rsp_any;

  // Unpack the flat operand buses into per-requester lanes.
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      req_x[k] = i_req_x[27*k +: 27];
      req_y[k] = i_req_y[27*k +: 27];
      req_z[k] = i_req_z[27*k +: 27];
    end
  end

  // Round-robin scan from the pointer upward (wrapping), first valid requester wins.
  always_comb begin
    o_req_ready = '0;
    gnt_any     = 1'b0;
    gnt_id      = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    sel_x       = '0;
    sel_y       = '0;
    sel_z       = '0;
    if (!i_rst && !i_stall) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        scan_sum = {1'b0, ptr} + (ID_W+1)'(i);
        if (scan_sum >= (ID_W+1)'(N_REQ)) begin
          scan_sum = scan_sum - (ID_W+1)'(N_REQ);
        end
        scan_idx = scan_sum[ID_W-1:0];
        if (!gnt_any && i_req_valid[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_id  = scan_idx;
          sel_x   = req_x[scan_idx];
          sel_y   = req_y[scan_idx];
          sel_z   = req_z[scan_idx];
        end
      end
      if (gnt_any) begin
        o_req_ready[gnt_id] = 1'b1;
      end
    end
  end

  // Issue register and round-robin pointer; idle cycles drive zero operands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr          <= '0;
      o_pipe_valid <= 1'b0;
      o_pipe_x     <= '0;
      o_pipe_y     <= '0;
      o_pipe_z     <= '0;
    end else begin
      o_pipe_valid <= gnt_any;
      o_pipe_x     <= sel_x;
      o_pipe_y     <= sel_y;
      o_pipe_z     <= sel_z;
      if (gnt_any) begin
        ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end
    end
  end

  // Tag delay line: stage 0 aligns with o_pipe_valid, stage LATENCY with the result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned j = 0; j <= LATENCY; j++) begin
        tag_v[j]  <= 1'b0;
        tag_id[j] <= '0;
      end
    end else begin
      tag_v[0]  <= gnt_any;
      tag_id[0] <= gnt_id;
      for (int unsigned j = 1; j <= LATENCY; j++) begin
        tag_v[j]  <= tag_v[j-1];
        tag_id[j] <= tag_id[j-1];
      end
    end
  end

  // Response register: capture the pipeline result and steer it by the matching tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid <= '0;
      o_rsp_id    <= '0;
      o_rsp_x     <= '0;
      o_rsp_y     <= '0;
      o_rsp_z     <= '0;
    end else begin
      o_rsp_x     <= i_pipe_x;
      o_rsp_y     <= i_pipe_y;
      o_rsp_z     <= i_pipe_z;
      o_rsp_id    <= tag_id[LATENCY];
      o_rsp_valid <= tag_v[LATENCY] ? (N_REQ'(1) << tag_id[LATENCY]) : '0;
    end
  end

  assign rsp_any = |o_rsp_valid;

  // Outstanding-operation counter: grants add, visible responses retire.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      inflight <= '0;
    end else if (gnt_any && !rsp_any) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!gnt_any && rsp_any) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  assign o_inflight = inflight;
  assign o_busy     = (inflight != '0);

endmodule

// File: doc/vec_normalize_scheduler.md
Name: vec_normalize_scheduler

Overview:
- Round-robin scheduler that shares one fixed-latency vector-normalize pipeline between N ray-marching requesters.
- Accepts at most one 3-vector per cycle, registers it into the shared pipeline, and tracks each in-flight operation with a tag delay line.
- Routes each result back to the requester that issued it.
- Sits between the per-pixel ray units and the single normalize datapath; operands and results are 27-bit floating point, passed through untouched.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LATENCY, 9, cycles from operands on o_pipe_* to result valid on i_pipe_*; pipeline is non-stallable.
- ID_W, $clog2(N_REQ), width of the requester index.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_req_valid  input  N_REQ  per-requester request strobe.
- i_req_x  input  27*N_REQ  packed x operands; requester k uses bits [27k+26:27k]. Same packing for i_req_y and i_req_z.
- i_req_y  input  27*N_REQ  packed y operands.
- i_req_z  input  27*N_REQ  packed z operands.
- o_req_ready  output  N_REQ  one-hot grant; the transfer occurs when valid and ready are both high.
- i_stall  input  1  suppresses all grants this cycle.
- o_pipe_valid  output  1  operands on o_pipe_* are a real issue.
- o_pipe_x, o_pipe_y, o_pipe_z  output  27 each  operands to the shared pipeline.
- i_pipe_x, i_pipe_y, i_pipe_z  input  27 each  results from the shared pipeline.
- o_rsp_valid  output  N_REQ  one-hot: response belongs to requester k.
- o_rsp_id  output  ID_W  index of the responding requester.
- o_rsp_x, o_rsp_y, o_rsp_z  output  27 each  normalized result, broadcast to all requesters.
- o_inflight  output  $clog2(LATENCY+3)  number of issued operations not yet responded.
- o_busy  output  1  o_inflight != 0.

Behaviour:
- Reset (synchronous, i_rst high at posedge):
  - o_pipe_valid=0, o_pipe_*=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_*=0, o_inflight=0, o_busy=0.
  - Round-robin pointer = 0; all tag-pipe valid bits = 0.
  - o_req_ready = 0 while i_rst is high.
- Arbitration (combinational in the cycle):
  - Grant goes to the first requester with valid set, scanning from the pointer upward and wrapping modulo N_REQ.
  - o_req_ready is one-hot on the granted requester, or all zero if no valid, i_stall, or i_rst.
  - ready never asserts for a requester whose valid is low.
- Pointer update: after a grant to k, pointer <= (k+1) mod N_REQ. With no grant, the pointer holds.
- Issue timing:
  - A grant at cycle t registers the granted operands into o_pipe_* with o_pipe_valid=1 during cycle t+1.
  - With no grant, o_pipe_valid=0 and o_pipe_* are driven to 0.
- Tag delay line:
  - LATENCY+1 stages of {valid, id}, entered alongside o_pipe_valid.
  - Stage LATENCY lines up with i_pipe_* valid at cycle t+1+LATENCY.
- Response timing:
  - At posedge ending cycle t+1+LATENCY: o_rsp_* <= i_pipe_*, o_rsp_id <= tag id, o_rsp_valid <= one-hot(id) if tag valid, else 0.
  - A response is visible in cycle t+2+LATENCY, so total request-to-response latency is LATENCY+2.
  - Responses cannot be back-pressured; the requester must accept.
- Throughput and ordering:
  - Sustains one issue per cycle.
  - Responses return in issue order.
  - No result is dropped or duplicated except on reset.
- o_inflight accounting:
  - +1 on grant, -1 on o_rsp_valid != 0 (registered).
  - Simultaneous grant and response: net 0.
  - Cannot exceed LATENCY+2.
- Reset mid-operation: all tags clear. Results still emerging from the pipeline afterwards have no valid tag and are discarded (o_rsp_valid stays 0). Counters restart at 0.
- i_stall: blocks new grants only. In-flight operations still complete and respond on schedule.
- Requester k changing operands while valid && !ready: allowed. Only the operands present in the grant cycle are issued.

Test Plan:
- Single request: requester 2 valid at cycle 5 with x=y=z=tag pattern 0x1234567, bench pipeline model = LATENCY delay line -> ready[2]=1 at cycle 5, o_pipe_valid at cycle 6, o_rsp_valid=4'b0100, id=2, o_rsp_x=0x1234567 at cycle 16 (LATENCY=9); o_inflight 1 during cycles 6-16, 0 at cycle 17.
- All four valid continuously from reset release -> grants 0,1,2,3,0,1... on consecutive cycles; responses in the same order with matching per-requester data, one per cycle; o_inflight saturates at 11.
- Fairness: requesters 0 and 3 continuously valid, pointer starting at 1 -> grants alternate 3,0,3,0; neither starves.
- Stall: all valid, i_stall high for cycles 10-12 -> no ready and o_pipe_valid=0 in cycles 11-13; responses show a 3-cycle gap; arbitration resumes from the held pointer.
- Reset mid-flight: 5 operations issued, i_rst pulsed one cycle at issue+3 -> outputs zero the next cycle; no o_rsp_valid for any of the 5; o_inflight=0; a new request after reset responds normally after 11 cycles.
- Grant/response collision: a new issue in the same cycle a response registers -> o_inflight unchanged; o_busy stays 1.
